// File: rtl/pdmafifo_pkg.sv
// rtl/pdmafifo_pkg.sv - shared defaults and pointer helper for the PDMA FIFO controller
//
// Purpose: default geometry, read latency and flag thresholds for the PDMA
// FIFO controller, plus the pointer-increment-with-wrap helper used by the
// read and write pointer counters.
// Ports: none (package).

package pdmafifo_pkg;

  localparam int AWIDTH_DEF    = 7;
  localparam int DEPTH_DEF     = 128;
  localparam int RD_LAT_DEF    = 1;
  localparam int AFULL_TH_DEF  = 120;
  localparam int AEMPTY_TH_DEF = 8;

  // Next pointer value. Wraps at depth-1 rather than at the address-space
  // limit, so a DEPTH below 2**AWIDTH never touches unused RAM words.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/pdmafifo_ptr_wrap.sv
// rtl/pdmafifo_ptr_wrap.sv - enabled address counter that wraps at DEPTH-1
//
// Purpose: RAM address pointer for the PDMA FIFO; advances by one on each
// enabled cycle and returns to 0 after DEPTH-1.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointer -> 0)
//   en     in   advance the pointer on this edge
//   ptr    out  AWIDTH-bit registered pointer

module pdmafifo_ptr_wrap
  import pdmafifo_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [AWIDTH-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= AWIDTH'(ptr_next(32'(ptr), 32'(DEPTH)));
    end
  end

endmodule

// File: rtl/pdmafifo_sync_ctrl.sv
// rtl/pdmafifo_sync_ctrl.sv - single-clock FIFO controller for the PDMA uSRAM wrapper
//
// Purpose: turns push/pop requests into RAM write/read strobes and addresses,
// tracks occupancy, and produces registered status flags, error pulses and a
// read-data-valid strobe aligned to the RAM read latency.
// Ports:
//   CLOCK      in   sole clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   WE / RE    in   push / pop requests
//   WEN / REN  out  RAM write / read strobes (combinational, request & !flag)
//   WADDR      out  RAM write address (write pointer)
//   RADDR      out  RAM read address (read pointer)
//   DVLD       out  RDATA valid, RD_LAT cycles after an accepted pop
//   FULL, EMPTY, AFULL, AEMPTY  out  registered status flags
//   WRCNT      out  occupancy 0..DEPTH
//   OVERFLOW   out  one-cycle pulse after WE while FULL
//   UNDERFLOW  out  one-cycle pulse after RE while EMPTY

module pdmafifo_sync_ctrl
  import pdmafifo_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic              RE,
  output logic              WEN,
  output logic [AWIDTH-1:0] WADDR,
  output logic              REN,
  output logic [AWIDTH-1:0] RADDR,
  output logic              DVLD,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [AWIDTH:0]   WRCNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_C  = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0] AEMPTY_C = (AWIDTH+1)'(AEMPTY_TH);

  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              aempty_q;
  logic              ovf_q;
  logic              udf_q;
  logic [AWIDTH:0]   cnt_q;
  logic [AWIDTH:0]   cnt_nxt;
  logic [RD_LAT-1:0] dvld_pipe;

  // Gating on the registered flags means a push at FULL is refused even when
  // a pop is accepted in the same cycle, and a pop at EMPTY never bypasses.
  assign WEN = WE & ~full_q;
  assign REN = RE & ~empty_q;

  pdmafifo_ptr_wrap #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_wptr (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .en    (WEN),
    .ptr   (WADDR)
  );

  pdmafifo_ptr_wrap #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_rptr (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .en    (REN),
    .ptr   (RADDR)
  );

  always_comb begin
    cnt_nxt = cnt_q;
    if (WEN && !REN) begin
      cnt_nxt = cnt_q + 1'b1;
    end else if (REN && !WEN) begin
      cnt_nxt = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      dvld_pipe <= '0;
    end else begin
      cnt_q     <= cnt_nxt;
      full_q    <= (cnt_nxt == DEPTH_C);
      empty_q   <= (cnt_nxt == '0);
      afull_q   <= (cnt_nxt >= AFULL_C);
      aempty_q  <= (cnt_nxt <= AEMPTY_C);
      ovf_q     <= WE & full_q;
      udf_q     <= RE & empty_q;
      // Bit 0 takes the new read strobe; the top bit leaves as DVLD.
      dvld_pipe <= RD_LAT'({dvld_pipe, REN});
    end
  end

  assign DVLD      = dvld_pipe[RD_LAT-1];
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign WRCNT     = cnt_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_pdmafifo_sync_ctrl.sv
// tb/tb_pdmafifo_sync_ctrl.sv - testbench for pdmafifo_sync_ctrl

module tb_pdmafifo_sync_ctrl;

  logic       clk;
  logic       rst_n;
  logic       we1, re1, we2, re2;

  logic       wen1, ren1, dvld1, full1, empty1, afull1, aempty1, ovf1, udf1;
  logic [6:0] waddr1, raddr1;
  logic [7:0] wrcnt1;
  logic       wen2, ren2, dvld2, full2, empty2, afull2, aempty2, ovf2, udf2;
  logic [6:0] waddr2, raddr2;
  logic [7:0] wrcnt2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q1[$];
  int q2[$];
  int e1, e2;

  pdmafifo_sync_ctrl u_dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we1), .RE(re1),
    .WEN(wen1), .WADDR(waddr1), .REN(ren1), .RADDR(raddr1), .DVLD(dvld1),
    .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
    .WRCNT(wrcnt1), .OVERFLOW(ovf1), .UNDERFLOW(udf1)
  );

  pdmafifo_sync_ctrl #(
    .AWIDTH(7), .DEPTH(100), .RD_LAT(2), .AFULL_TH(90), .AEMPTY_TH(8)
  ) u_dut2 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we2), .RE(re2),
    .WEN(wen2), .WADDR(waddr2), .REN(ren2), .RADDR(raddr2), .DVLD(dvld2),
    .FULL(full2), .EMPTY(empty2), .AFULL(afull2), .AEMPTY(aempty2),
    .WRCNT(wrcnt2), .OVERFLOW(ovf2), .UNDERFLOW(udf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // DVLD scoreboards: the driver queues the cycle in which each accepted pop
  // must show DVLD; these monitors consume entries as DVLD appears.
  always @(negedge clk) begin
    if (dvld1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dvld1_unexpected: DVLD=1 at cycle %0d, expected 0", cyc);
      end else begin
        e1 = q1.pop_front();
        if (e1 != cyc) begin
          errors++;
          $display("FAIL dvld1_cycle: DVLD at cycle %0d, expected cycle %0d", cyc, e1);
        end
      end
    end else if (q1.size() != 0 && q1[0] <= cyc) begin
      checks++;
      errors++;
      e1 = q1.pop_front();
      $display("FAIL dvld1_missing: DVLD=0 at cycle %0d, expected 1 (due cycle %0d)", cyc, e1);
    end
  end

  always @(negedge clk) begin
    if (dvld2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dvld2_unexpected: DVLD=1 at cycle %0d, expected 0", cyc);
      end else begin
        e2 = q2.pop_front();
        if (e2 != cyc) begin
          errors++;
          $display("FAIL dvld2_cycle: DVLD at cycle %0d, expected cycle %0d", cyc, e2);
        end
      end
    end else if (q2.size() != 0 && q2[0] <= cyc) begin
      checks++;
      errors++;
      e2 = q2.pop_front();
      $display("FAIL dvld2_missing: DVLD=0 at cycle %0d, expected 1 (due cycle %0d)", cyc, e2);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat[4];
    pat = '{1, 1, 0, 1};
    rst_n = 1'b0;
    we1 = 1'b0; re1 = 1'b0; we2 = 1'b0; re2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_empty", empty1, 1);
    chk("rst_aempty", aempty1, 1);
    chk("rst_full", full1, 0);
    chk("rst_afull", afull1, 0);
    chk("rst_wrcnt", wrcnt1, 0);
    chk("rst_waddr", waddr1, 0);
    chk("rst_raddr", raddr1, 0);
    chk("rst_dvld", dvld1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_udf", udf1, 0);
    chk("rst_empty2", empty2, 1);

    // 128 pushes with no pops
    for (int i = 0; i < 128; i++) begin
      we1 = 1'b1;
      #1;
      chk("push_wen", wen1, 1);
      chk("push_waddr", waddr1, i);
      @(negedge clk);
      chk("push_wrcnt", wrcnt1, i + 1);
      chk("push_afull", afull1, (i + 1 >= 120) ? 1 : 0);
      chk("push_aempty", aempty1, (i + 1 <= 8) ? 1 : 0);
      chk("push_full", full1, (i == 127) ? 1 : 0);
      chk("push_empty", empty1, 0);
    end
    // 129th push is refused
    #1;
    chk("ovf_wen", wen1, 0);
    chk("ovf_waddr_wrapped", waddr1, 0);
    @(negedge clk);
    chk("ovf_pulse", ovf1, 1);
    chk("ovf_wrcnt", wrcnt1, 128);
    we1 = 1'b0;
    @(negedge clk);
    chk("ovf_pulse_end", ovf1, 0);

    // 128 pops back to empty
    for (int i = 0; i < 128; i++) begin
      re1 = 1'b1;
      q1.push_back(cyc + 1);
      #1;
      chk("pop_ren", ren1, 1);
      chk("pop_raddr", raddr1, i);
      @(negedge clk);
      chk("pop_wrcnt", wrcnt1, 127 - i);
      chk("pop_empty", empty1, (i == 127) ? 1 : 0);
      chk("pop_aempty", aempty1, (127 - i <= 8) ? 1 : 0);
      chk("pop_full", full1, 0);
    end
    #1;
    chk("udf_ren", ren1, 0);
    chk("udf_raddr_wrapped", raddr1, 0);
    @(negedge clk);
    chk("udf_pulse", udf1, 1);
    chk("udf_wrcnt", wrcnt1, 0);
    re1 = 1'b0;
    @(negedge clk);
    chk("udf_pulse_end", udf1, 0);

    // Push and pop together at EMPTY: push only, no DVLD
    we1 = 1'b1; re1 = 1'b1;
    #1;
    chk("both_empty_wen", wen1, 1);
    chk("both_empty_ren", ren1, 0);
    @(negedge clk);
    chk("both_empty_wrcnt", wrcnt1, 1);
    chk("both_empty_udf", udf1, 1);
    chk("both_empty_empty", empty1, 0);
    re1 = 1'b0;
    repeat (127) @(negedge clk);
    chk("refill_full", full1, 1);
    chk("refill_wrcnt", wrcnt1, 128);

    // Push and pop together at FULL: pop only
    re1 = 1'b1;
    q1.push_back(cyc + 1);
    #1;
    chk("both_full_wen", wen1, 0);
    chk("both_full_ren", ren1, 1);
    @(negedge clk);
    chk("both_full_wrcnt", wrcnt1, 127);
    chk("both_full_full", full1, 0);
    chk("both_full_ovf", ovf1, 1);
    we1 = 1'b0; re1 = 1'b0;
    repeat (3) @(negedge clk);

    // DEPTH=100 instance: occupancy 10 then 150 push/pop pairs across the wrap
    we2 = 1'b1;
    repeat (10) @(negedge clk);
    chk("d100_fill_wrcnt", wrcnt2, 10);
    for (int j = 0; j < 150; j++) begin
      we2 = 1'b1; re2 = 1'b1;
      q2.push_back(cyc + 2);
      #1;
      chk("d100_waddr", waddr2, (10 + j) % 100);
      chk("d100_raddr", raddr2, j % 100);
      @(negedge clk);
    end
    we2 = 1'b0; re2 = 1'b0;
    chk("d100_pairs_wrcnt", wrcnt2, 10);
    chk("d100_waddr_end", waddr2, 60);
    chk("d100_raddr_end", raddr2, 50);
    repeat (4) @(negedge clk);

    // RD_LAT=2: pops on cycles 0,1,3 of a window give DVLD on 2,3,5
    for (int k = 0; k < 4; k++) begin
      re2 = pat[k][0];
      if (pat[k] != 0) q2.push_back(cyc + 2);
      @(negedge clk);
    end
    re2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat2_wrcnt", wrcnt2, 7);

    // Asynchronous reset with reads in flight
    re2 = 1'b1;
    q2.push_back(cyc + 2);
    @(negedge clk);
    q2.push_back(cyc + 2);
    @(posedge clk);
    #2;
    re2 = 1'b0;
    chk("inflight_dvld", dvld2, 1);
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    chk("arst_dvld", dvld2, 0);
    chk("arst_wrcnt2", wrcnt2, 0);
    chk("arst_waddr2", waddr2, 0);
    chk("arst_raddr2", raddr2, 0);
    chk("arst_empty2", empty2, 1);
    chk("arst_wrcnt1", wrcnt1, 0);
    chk("arst_full1", full1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_dvld", dvld2, 0);
    chk("post_rst_empty2", empty2, 1);
    chk("post_rst_aempty2", aempty2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
